// File: rtl/tick_monitor.sv
// Observes an asynchronous divided clock, emits one-cycle edge ticks and checks
// each edge-to-edge interval against EXP_HALF +/- TOL with sticky error flags.
module tick_monitor #(
  parameter int EXP_HALF = 7500000,
  parameter int TOL      = 16,
  parameter int CW       = 33
) (
  input  logic          in_clk,
  input  logic          rst,
  input  logic          slow_clk,
  input  logic          clear,
  output logic          rise_tick,
  output logic          fall_tick,
  output logic [CW-1:0] half_period,
  output logic          period_valid,
  output logic          err_fast,
  output logic          err_slow
);

  typedef enum logic [1:0] {
    SEEK  = 2'd0,
    TRACK = 2'd1,
    LOST  = 2'd2
  } state_e;

  localparam logic [CW-1:0] MIN_C  = CW'(EXP_HALF - TOL);
  localparam logic [CW-1:0] MAX_C  = CW'(EXP_HALF + TOL);
  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] SAT_C  = {CW{1'b1}};

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == SAT_C) begin
      return SAT_C;
    end else begin
      return v + ONE_C;
    end
  endfunction

  state_e        state_q, state_d;
  logic          sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
  logic [1:0]    prime_q, prime_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] half_period_q, half_period_d;
  logic          period_valid_q, period_valid_d;
  logic          rise_tick_q, rise_tick_d, fall_tick_q, fall_tick_d;
  logic          err_fast_q, err_fast_d, err_slow_q, err_slow_d;
  logic          primed_s, edge_s, set_fast_s, set_slow_s;
  logic [CW-1:0] meas_s;

  // Next-state, measurement and flag logic.
  always_comb begin
    sync1_d        = slow_clk;
    sync2_d        = sync1_q;
    hist_d         = sync2_q;
    state_d        = state_q;
    half_period_d  = half_period_q;
    period_valid_d = period_valid_q;
    set_fast_s     = 1'b0;
    set_slow_s     = 1'b0;

    if (prime_q == 2'd3) begin
      prime_d = prime_q;
    end else begin
      prime_d = prime_q + 2'd1;
    end
    primed_s = (prime_q == 2'd3);
    edge_s   = primed_s && (sync2_q != hist_q);
    // meas_s is the interval that would be reported if an edge lands this cycle.
    meas_s   = sat_inc(cnt_q);
    cnt_d    = meas_s;

    case (state_q)
      SEEK: begin
        if (edge_s) begin
          state_d = TRACK;
          cnt_d   = ZERO_C;
        end else begin
          cnt_d   = meas_s;
        end
      end
      TRACK: begin
        if (edge_s) begin
          cnt_d         = ZERO_C;
          half_period_d = meas_s;
          if (meas_s < MIN_C) begin
            set_fast_s     = 1'b1;
            period_valid_d = 1'b0;
          end else if (meas_s > MAX_C) begin
            set_slow_s     = 1'b1;
            period_valid_d = 1'b0;
          end else begin
            period_valid_d = 1'b1;
          end
        end else if (meas_s > MAX_C) begin
          set_slow_s     = 1'b1;
          period_valid_d = 1'b0;
          state_d        = LOST;
        end else begin
          state_d = TRACK;
        end
      end
      LOST: begin
        if (edge_s) begin
          state_d = TRACK;
          cnt_d   = ZERO_C;
        end else begin
          state_d = LOST;
        end
      end
      default: begin
        state_d = SEEK;
        cnt_d   = ZERO_C;
      end
    endcase

    rise_tick_d = edge_s && sync2_q;
    fall_tick_d = edge_s && !sync2_q;
    err_fast_d  = (err_fast_q && !clear) || set_fast_s;
    err_slow_d  = (err_slow_q && !clear) || set_slow_s;
  end

  // State and output registers.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      state_q        <= SEEK;
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      hist_q         <= 1'b0;
      prime_q        <= 2'd0;
      cnt_q          <= ZERO_C;
      half_period_q  <= ZERO_C;
      period_valid_q <= 1'b0;
      rise_tick_q    <= 1'b0;
      fall_tick_q    <= 1'b0;
      err_fast_q     <= 1'b0;
      err_slow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      hist_q         <= hist_d;
      prime_q        <= prime_d;
      cnt_q          <= cnt_d;
      half_period_q  <= half_period_d;
      period_valid_q <= period_valid_d;
      rise_tick_q    <= rise_tick_d;
      fall_tick_q    <= fall_tick_d;
      err_fast_q     <= err_fast_d;
      err_slow_q     <= err_slow_d;
    end
  end

  assign rise_tick    = rise_tick_q;
  assign fall_tick    = fall_tick_q;
  assign half_period  = half_period_q;
  assign period_valid = period_valid_q;
  assign err_fast     = err_fast_q;
  assign err_slow     = err_slow_q;

endmodule

// File: tb/tb_tick_monitor.sv
// Self-checking bench for tick_monitor (EXP_HALF=10, TOL=2, CW=8): directed
// table, hand-written corner sequences and random stimulus against a model.
module tb_tick_monitor;

  logic       in_clk = 1'b0;
  logic       rst = 1'b0;
  logic       slow_clk = 1'b0;
  logic       clear = 1'b0;
  logic       rise_tick, fall_tick, period_valid, err_fast, err_slow;
  logic [7:0] half_period;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tick_t[$];
  int tick_r[$];

  // Reference model: events derived from the sampled level history.
  int lv[$];
  int t, mode, last_ev;
  int m_rise, m_fall, m_hp, m_pv, m_ef, m_es;

  tick_monitor #(.EXP_HALF(10), .TOL(2), .CW(8)) dut (
    .in_clk(in_clk), .rst(rst), .slow_clk(slow_clk), .clear(clear),
    .rise_tick(rise_tick), .fall_tick(fall_tick), .half_period(half_period),
    .period_valid(period_valid), .err_fast(err_fast), .err_slow(err_slow)
  );

  always #5 in_clk = ~in_clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    lv.delete();
    t = 0; mode = 0; last_ev = 0;
    m_rise = 0; m_fall = 0; m_hp = 0; m_pv = 0; m_ef = 0; m_es = 0;
  endtask

  // mode: 0 = no edge yet, 1 = timing between edges, 2 = timed out
  task automatic model_step(input int s, input int c);
    int ev, n, sf, ss;
    t++;
    lv.push_back(s);
    ev = 0; sf = 0; ss = 0;
    if (t >= 4) ev = (lv[t-3] != lv[t-4]) ? 1 : 0;
    m_rise = (ev == 1 && lv[t-3] == 1) ? 1 : 0;
    m_fall = (ev == 1 && lv[t-3] == 0) ? 1 : 0;
    if (ev == 1) begin
      if (mode == 1) begin
        n = t - last_ev;
        m_hp = n;
        if (n < 8) begin sf = 1; m_pv = 0; end
        else if (n > 12) begin ss = 1; m_pv = 0; end
        else m_pv = 1;
      end
      mode = 1;
      last_ev = t;
    end else if (mode == 1 && t - last_ev >= 13) begin
      ss = 1; m_pv = 0; mode = 2;
    end
    m_ef = ((m_ef == 1 && c == 0) || sf == 1) ? 1 : 0;
    m_es = ((m_es == 1 && c == 0) || ss == 1) ? 1 : 0;
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic cycle(input logic s, input logic c);
    slow_clk = s;
    clear = c;
    @(posedge in_clk);
    model_step(int'(s), int'(c));
    @(negedge in_clk);
    cyc++;
    chk("rise_tick", int'(rise_tick), m_rise);
    chk("fall_tick", int'(fall_tick), m_fall);
    chk("half_period", int'(half_period), m_hp);
    chk("period_valid", int'(period_valid), m_pv);
    chk("err_fast", int'(err_fast), m_ef);
    chk("err_slow", int'(err_slow), m_es);
    if (rise_tick || fall_tick) begin
      tick_t.push_back(cyc);
      tick_r.push_back(int'(rise_tick));
    end
  endtask

  task automatic run_level(input logic s, input int n);
    for (int i = 0; i < n; i++) cycle(s, 1'b0);
  endtask

  task automatic do_reset(input logic s);
    rst = 1'b0;
    slow_clk = s;
    clear = 1'b0;
    model_reset();
    repeat (2) @(negedge in_clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic s; logic c;
    logic r; logic f; int hp; logic pv; logic ef; logic es;
  } vec_t;

  vec_t tbl[9];
  int   nrise;
  logic lvl;

  initial begin
    // Glitch after priming: one cycle high sampled at edge 4.
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0};

    model_reset();
    repeat (2) @(negedge in_clk);
    chk("reset_rise", int'(rise_tick), 0);
    chk("reset_fall", int'(fall_tick), 0);
    chk("reset_hp", int'(half_period), 0);
    chk("reset_pv", int'(period_valid), 0);
    chk("reset_ef", int'(err_fast), 0);
    chk("reset_es", int'(err_slow), 0);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].s, tbl[i].c);
      chk("tbl_rise", int'(rise_tick), int'(tbl[i].r));
      chk("tbl_fall", int'(fall_tick), int'(tbl[i].f));
      chk("tbl_hp", int'(half_period), tbl[i].hp);
      chk("tbl_pv", int'(period_valid), int'(tbl[i].pv));
      chk("tbl_ef", int'(err_fast), int'(tbl[i].ef));
      chk("tbl_es", int'(err_slow), int'(tbl[i].es));
    end

    // Square wave, half-period 10.
    do_reset(1'b0);
    run_level(1'b0, 5);
    tick_t.delete(); tick_r.delete();
    for (int k = 0; k < 6; k++) run_level((k % 2 == 0) ? 1'b1 : 1'b0, 10);
    chk("sq_count", tick_t.size(), 6);
    for (int i = 0; i < tick_t.size(); i++) begin
      chk("sq_alternate", tick_r[i], (i % 2 == 0) ? 1 : 0);
      if (i > 0) chk("sq_spacing", tick_t[i] - tick_t[i-1], 10);
    end
    chk("sq_hp", int'(half_period), 10);
    chk("sq_pv", int'(period_valid), 1);
    chk("sq_errs", int'({err_fast, err_slow}), 0);

    // Short half-period of 6, recovery, then clear.
    run_level(1'b1, 6);
    run_level(1'b0, 3);
    chk("fast_hp", int'(half_period), 6);
    chk("fast_ef", int'(err_fast), 1);
    chk("fast_pv", int'(period_valid), 0);
    run_level(1'b0, 7);
    run_level(1'b1, 3);
    chk("recover_hp", int'(half_period), 10);
    chk("recover_pv", int'(period_valid), 1);
    chk("recover_ef", int'(err_fast), 1);
    cycle(1'b1, 1'b1);
    chk("clear_ef", int'(err_fast), 0);
    run_level(1'b1, 6);

    // Static input: timeout 13 cycles after the last edge, clear in the same cycle.
    run_level(1'b0, 3);
    chk("pre_timeout_pv", int'(period_valid), 1);
    run_level(1'b0, 12);
    chk("pre_timeout_es", int'(err_slow), 0);
    cycle(1'b0, 1'b1);
    chk("timeout_es_set_wins", int'(err_slow), 1);
    chk("timeout_pv", int'(period_valid), 0);
    cycle(1'b0, 1'b0);
    chk("timeout_es_sticky", int'(err_slow), 1);
    run_level(1'b1, 3);
    chk("lost_edge_hp", int'(half_period), 10);
    chk("lost_edge_pv", int'(period_valid), 0);
    run_level(1'b1, 7);
    run_level(1'b0, 3);
    chk("relock_hp", int'(half_period), 10);
    chk("relock_pv", int'(period_valid), 1);

    // Asynchronous reset mid-interval.
    run_level(1'b0, 4);
    #2 rst = 1'b0;
    #1;
    chk("midrst_rise", int'(rise_tick), 0);
    chk("midrst_fall", int'(fall_tick), 0);
    chk("midrst_hp", int'(half_period), 0);
    chk("midrst_pv", int'(period_valid), 0);
    chk("midrst_ef", int'(err_fast), 0);
    chk("midrst_es", int'(err_slow), 0);
    model_reset();
    slow_clk = 1'b1;
    repeat (2) @(negedge in_clk);
    rst = 1'b1;
    tick_t.delete(); tick_r.delete();
    run_level(1'b1, 8);
    nrise = 0;
    foreach (tick_r[i]) nrise += tick_r[i];
    chk("prime_no_rise", nrise, 0);
    run_level(1'b0, 5);

    // Random half-periods and clears against the model.
    do_reset(1'b0);
    lvl = 1'b0;
    for (int seg = 0; seg < 80; seg++) begin
      int r, len;
      r = $urandom_range(0, 9);
      if (r < 2) len = $urandom_range(1, 7);
      else if (r < 8) len = $urandom_range(8, 12);
      else len = $urandom_range(14, 20);
      if (seg == 40) begin
        lvl = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
        do_reset(lvl);
      end
      lvl = ~lvl;
      for (int i = 0; i < len; i++) cycle(lvl, ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_monitor.md
TICK_MONITOR -- requirements
Module: tick_monitor

Interface
REQ-001 SHALL have parameter EXP_HALF, default 7500000, meaning expected slow_clk half-period in in_clk cycles.
REQ-002 SHALL have parameter TOL, default 16, meaning allowed +/- deviation in cycles.
REQ-003 SHALL have parameter CW, default 33, meaning counter and measurement width.
REQ-004 SHALL have port in_clk, input, 1 bit: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port slow_clk, input, 1 bit: divided clock under observation, treated as asynchronous.
REQ-007 SHALL have port clear, input, 1 bit: synchronous clear of sticky error flags.
REQ-008 SHALL have port rise_tick, output, 1 bit: one-cycle pulse per slow_clk rising edge.
REQ-009 SHALL have port fall_tick, output, 1 bit: one-cycle pulse per slow_clk falling edge.
REQ-010 SHALL have port half_period, output, CW bits: last measured edge-to-edge interval.
REQ-011 SHALL have port period_valid, output, 1 bit: last measurement in range and monitor locked.
REQ-012 SHALL have port err_fast, output, 1 bit: sticky flag, interval shorter than EXP_HALF-TOL.
REQ-013 SHALL have port err_slow, output, 1 bit: sticky flag, no edge within EXP_HALF+TOL cycles.

Function
REQ-014 SHALL sample slow_clk through a 2-flop synchronizer followed by one history flop; an edge event is sync stage 2 differing from the history flop.
REQ-015 SHALL register rise_tick/fall_tick so that a level first sampled at in_clk edge k produces a tick high for exactly the cycle following edge k+2.
REQ-016 SHALL never assert rise_tick and fall_tick in the same cycle.
REQ-017 SHALL suppress ticks and measurements for the first 3 cycles after reset release (priming), so a slow_clk already high at release causes no tick.
REQ-018 SHALL implement states SEEK (no edge seen yet), TRACK (timing between edges), LOST (timeout).
REQ-019 SEEK: on the first edge event -> TRACK, interval counter cleared; half_period unchanged.
REQ-020 TRACK: on each edge event, load half_period with the in_clk cycle count since the previous edge event (consecutive edge events N cycles apart give N), then restart the count.
REQ-021 TRACK: measurement within [EXP_HALF-TOL, EXP_HALF+TOL] sets period_valid=1, registered the cycle after the edge event.
REQ-022 TRACK: measurement < EXP_HALF-TOL sets err_fast=1 and period_valid=0; remains in TRACK.
REQ-023 TRACK: count reaching EXP_HALF+TOL+1 without an edge sets err_slow=1 and period_valid=0, and moves to LOST.
REQ-024 LOST: on an edge event -> TRACK with the count restarted; half_period is not loaded from the LOST interval; period_valid stays 0 until a subsequent in-range measurement.
REQ-025 Counter SHALL saturate at 2^CW-1 and never wrap.
REQ-026 clear deasserts err_fast/err_slow the next cycle; if an error condition occurs in the same cycle as clear, the error flag SHALL be set (set wins).
REQ-027 clear SHALL NOT affect state, counter, half_period or period_valid.

Reset
REQ-028 On rst low, immediately: state=SEEK, synchronizer/history flops=0, counter=0, half_period=0, rise_tick=fall_tick=0, period_valid=0, err_fast=err_slow=0.
REQ-029 Reset asserted mid-measurement SHALL discard the partial count; after release, behaviour restarts from REQ-017.

Verification (EXP_HALF=10, TOL=2, CW=8)
REQ-030 slow_clk square wave, 10-cycle half-period -> alternating rise/fall ticks 10 cycles apart, half_period=10, period_valid=1 from second edge onward, no errors.
REQ-031 slow_clk rises at edge k -> rise_tick high only in the cycle after edge k+2; a 1-cycle slow_clk glitch after settling -> exactly one rise_tick and one fall_tick.
REQ-032 One half-period of 6 -> err_fast=1, period_valid=0, half_period=6; next 10-cycle interval -> period_valid=1, err_fast still 1; pulse clear -> err_fast=0 next cycle.
REQ-033 slow_clk held static -> err_slow=1 and state LOST 13 cycles after last edge event; resume toggling at 10 -> first edge gives no measurement, second gives half_period=10, period_valid=1.
REQ-034 slow_clk high during reset, rst released -> no rise_tick; rst pulsed low mid-interval -> all outputs 0 immediately.
REQ-035 clear held high in the cycle err_slow timeout occurs -> err_slow=1.
